dram_core: RTL and testbench
============================

DRAM_CORE -- requirements
Module: dram_core

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: stored-word address width; the word address is {row, col} truncated to ADDR_W LSBs.
REQ-002 SHALL have parameter CL, default 5: CAS read latency in cycles.
REQ-003 SHALL have parameter TRCD, default 4: minimum cycles from ACT to CAS.
REQ-004 SHALL have parameter TRP, default 4: minimum cycles from PRE to ACT.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port CSn, input, 1 bit: chip select, active-low; when high, all commands are ignored.
REQ-008 SHALL have port RASn, input, 1 bit: row strobe, active-low.
REQ-009 SHALL have port CASn, input, 1 bit: column strobe, active-low.
REQ-010 SHALL have port WEn, input, `AXI_STRB_BITS wide: per-byte write enables, active-low.
REQ-011 SHALL have port addrDRAM, input, `RAM_ADDR_BITS wide: row address on ACT, column address on CAS.
REQ-012 SHALL have port writeD, input, `RAM_DATA_BITS wide: write data, sampled on the write-CAS cycle.
REQ-013 SHALL have port readQ, output, `RAM_DATA_BITS wide: read data.
REQ-014 SHALL have port dramValid, output, 2 bits: both bits high for exactly the one cycle readQ is valid.

Function
REQ-015 SHALL decode the following commands on each posedge with CSn=0:
- ACT: RASn=0, CASn=1, WEn all-ones.
- PRE: RASn=0, CASn=1, WEn all-zeros.
- RD: RASn=1, CASn=0, WEn all-ones.
- WR: RASn=1, CASn=0, WEn not all-ones.
REQ-016 SHALL have bank FSM states IDLE (no open row) and OPEN (row latched); IDLE-ACT->OPEN latches addrDRAM as the open row; OPEN-PRE->IDLE.
REQ-017 SHALL keep the open row unchanged and leave the state in OPEN on ACT while OPEN; PRE while IDLE SHALL be a no-op.
REQ-018 SHALL, on WR while OPEN, write each byte i of writeD where WEn[i]=0 at word {row, col} in the same cycle; other bytes SHALL be unchanged.
REQ-019 SHALL, on RD while OPEN, read the array in the command cycle and carry the data through a CL-deep pipeline; readQ updates and dramValid=2'b11 exactly CL cycles after the RD edge.
REQ-020 SHALL accept back-to-back RDs every cycle, each returning in order with single-cycle dramValid.
REQ-021 SHALL complete in-flight read data even if a PRE or ACT follows.
REQ-022 SHALL make a RD following a WR to the same word in the next cycle return the new data.
REQ-023 SHALL hold readQ at its last value whenever dramValid=0.
REQ-024 SHALL ignore RD/WR while IDLE: no array change and no dramValid.
REQ-025 SHALL ignore any cycle with RASn=0 and CASn=0, and SHALL ignore RASn=0 with WEn mixed (neither all-ones nor all-zeros).

Reset
REQ-026 SHALL, while rst=0, immediately force: FSM IDLE, read pipeline empty, dramValid=2'b00, readQ=0, timing counters saturated (no violation pending).
REQ-027 SHALL drop in-flight reads on a reset mid-burst (no dramValid after release) and SHALL NOT clear array contents.

Configuration
REQ-028 SHALL, with DRAM_TIMING_CHECK_EN defined, add output timingErr (1 bit), pulsed for one cycle when any of the following occurs:
- CAS issued fewer than TRCD cycles after ACT;
- ACT issued fewer than TRP cycles after PRE;
- an ignored command per REQ-017, REQ-024 or REQ-025.
REQ-029 SHALL, without DRAM_TIMING_CHECK_EN, omit the timingErr port and all counters; functional behaviour is identical either way.

Structure
REQ-030 SHALL place command encoding (ACT/PRE/RD/WR/NOP enum) and the bank-state enum in shared package dram_pkg; CL/TRCD/TRP defaults SHALL be package constants.
REQ-031 SHALL hold storage in sub-module dram_array: 2^ADDR_W words, byte-write, combinational read.

Verification
REQ-032 SHALL cover: ACT row 0x003, wait 4, WR col 0x010 data 0xDEADBEEF with WEn=4'h0, RD col 0x010 -> dramValid=2'b11 exactly 5 cycles later, readQ=0xDEADBEEF.
REQ-033 SHALL cover: WR 0xFFFFFFFF then WR 0x00000000 with WEn=4'b1100, RD -> readQ=0xFFFF0000.
REQ-034 SHALL cover: 4 back-to-back RDs to cols 0..3 -> 4 consecutive dramValid cycles with data in order.
REQ-035 SHALL cover: RD then PRE on the next cycle -> data still returned at +5; a subsequent RD while IDLE -> no dramValid.
REQ-036 SHALL cover, with DRAM_TIMING_CHECK_EN: ACT then RD 2 cycles later -> timingErr=1 for one cycle; the read is still serviced.
REQ-037 SHALL cover: rst low 2 cycles after an RD -> dramValid stays 0; data written before the reset reads back correctly after it.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM core model: bus widths, command and
// bank-state encodings, and default timing parameters.
// Optional feature macro: DRAM_TIMING_CHECK_EN (adds the timingErr output).

`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 8
`endif
`ifndef RAM_DATA_BITS
`define RAM_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package dram_pkg;

    localparam int DRAM_CL_DEF   = 5;
    localparam int DRAM_TRCD_DEF = 4;
    localparam int DRAM_TRP_DEF  = 4;

    localparam int STRB_W = `AXI_STRB_BITS;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_PRE,
        CMD_RD,
        CMD_WR,
        CMD_ILL
    } dram_cmd_e;

    typedef enum logic {
        BANK_IDLE,
        BANK_OPEN
    } bank_state_e;

    // Strobe decode; RAS+CAS together or RAS with mixed byte enables is illegal.
    function automatic dram_cmd_e decode_cmd(input logic cs_n,
                                             input logic ras_n,
                                             input logic cas_n,
                                             input logic [STRB_W-1:0] we_n);
        dram_cmd_e c;
        c = CMD_NOP;
        if (!cs_n) begin
            if (!ras_n && !cas_n) begin
                c = CMD_ILL;
            end else if (!ras_n) begin
                if (&we_n)        c = CMD_ACT;
                else if (~|we_n)  c = CMD_PRE;
                else              c = CMD_ILL;
            end else if (!cas_n) begin
                if (&we_n) c = CMD_RD;
                else       c = CMD_WR;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/dram_array.sv
// Word storage with per-byte write enables and combinational read.
// Holds no reset so contents survive a core reset.

module dram_array #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [STRB_W-1:0] be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    // Byte-lane writes into the addressed word.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (be_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dram_core.sv
// Single-bank DRAM behavioural core: command decode, bank FSM, CL-deep
// read pipeline. Defining DRAM_TIMING_CHECK_EN adds tRCD/tRP checking and
// the timingErr output; functional behaviour is the same either way.
//
// state     | meaning
// ----------+------------------------------------------
// BANK_IDLE | no open row; RD/WR/PRE are ignored
// BANK_OPEN | row latched in row_q; ACT is ignored

module dram_core import dram_pkg::*; #(
    parameter int ADDR_W = 16,
    parameter int CL     = DRAM_CL_DEF,
    parameter int TRCD   = DRAM_TRCD_DEF,
    parameter int TRP    = DRAM_TRP_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        CSn,
    input  logic                        RASn,
    input  logic                        CASn,
    input  logic [`AXI_STRB_BITS-1:0]   WEn,
    input  logic [`RAM_ADDR_BITS-1:0]   addrDRAM,
    input  logic [`RAM_DATA_BITS-1:0]   writeD,
    output logic [`RAM_DATA_BITS-1:0]   readQ,
    output logic [1:0]                  dramValid
`ifdef DRAM_TIMING_CHECK_EN
    ,
    output logic                        timingErr
`endif
);

    localparam int DATA_W = `RAM_DATA_BITS;
    localparam int RAB    = `RAM_ADDR_BITS;

    dram_cmd_e          cmd;
    bank_state_e        state_q, state_d;
    logic [RAB-1:0]     row_q, row_d;
    logic               rd_fire, wr_fire;
    logic [ADDR_W-1:0]  word_addr;
    logic [STRB_W-1:0]  be;
    logic [DATA_W-1:0]  rdata;

    logic [CL-1:0]      rd_vld_q;
    logic [DATA_W-1:0]  rd_data_q [CL];
    logic               valid_q;
    logic [DATA_W-1:0]  rdq_q;

    assign cmd       = decode_cmd(CSn, RASn, CASn, WEn);
    assign word_addr = ADDR_W'({row_q, addrDRAM});
    assign be        = wr_fire ? ~WEn : '0;

    // Bank state and open-row register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BANK_IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Next-state and command-accept decisions.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        case (cmd)
            CMD_ACT: if (state_q == BANK_IDLE) begin
                state_d = BANK_OPEN;
                row_d   = addrDRAM;
            end
            CMD_PRE: if (state_q == BANK_OPEN) state_d = BANK_IDLE;
            CMD_RD:  rd_fire = (state_q == BANK_OPEN);
            CMD_WR:  wr_fire = (state_q == BANK_OPEN);
            default: ;
        endcase
    end

    dram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) u_array (
        .clk_i   (clk),
        .addr_i  (word_addr),
        .be_i    (be),
        .wdata_i (writeD),
        .rdata_o (rdata)
    );

    // Read latency pipeline; the output register adds the final cycle so data
    // appears exactly CL edges after the RD edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_q <= '0;
            for (int i = 0; i < CL; i++) rd_data_q[i] <= '0;
            valid_q  <= 1'b0;
            rdq_q    <= '0;
        end else begin
            rd_vld_q[0]  <= rd_fire;
            rd_data_q[0] <= rdata;
            for (int i = 1; i < CL; i++) begin
                rd_vld_q[i]  <= rd_vld_q[i-1];
                rd_data_q[i] <= rd_data_q[i-1];
            end
            valid_q <= rd_vld_q[CL-1];
            if (rd_vld_q[CL-1]) rdq_q <= rd_data_q[CL-1];
        end
    end

    assign readQ     = rdq_q;
    assign dramValid = {2{valid_q}};

`ifdef DRAM_TIMING_CHECK_EN
    localparam int TMAX  = (TRCD > TRP) ? TRCD : TRP;
    localparam int CNT_W = $clog2(TMAX + 1);

    logic [CNT_W-1:0] trcd_cnt_q, trp_cnt_q;
    logic             timing_err_q;
    logic             cmd_ignored, trcd_viol, trp_viol;

    assign cmd_ignored = (cmd == CMD_ILL)
                       || ((cmd == CMD_ACT) && (state_q == BANK_OPEN))
                       || (((cmd == CMD_PRE) || (cmd == CMD_RD) || (cmd == CMD_WR))
                           && (state_q == BANK_IDLE));
    assign trcd_viol   = (rd_fire || wr_fire) && (trcd_cnt_q != '0);
    assign trp_viol    = (cmd == CMD_ACT) && (state_q == BANK_IDLE) && (trp_cnt_q != '0);

    // Down-counters loaded on accepted ACT/PRE; zero means the window has elapsed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trcd_cnt_q   <= '0;
            trp_cnt_q    <= '0;
            timing_err_q <= 1'b0;
        end else begin
            if ((cmd == CMD_ACT) && (state_q == BANK_IDLE))
                trcd_cnt_q <= CNT_W'(TRCD - 1);
            else if (trcd_cnt_q != '0)
                trcd_cnt_q <= trcd_cnt_q - 1'b1;
            if ((cmd == CMD_PRE) && (state_q == BANK_OPEN))
                trp_cnt_q <= CNT_W'(TRP - 1);
            else if (trp_cnt_q != '0)
                trp_cnt_q <= trp_cnt_q - 1'b1;
            timing_err_q <= trcd_viol || trp_viol || cmd_ignored;
        end
    end

    assign timingErr = timing_err_q;
`endif

endmodule

// File: tb/tb_dram_core.sv
// Directed self-checking bench for dram_core with hand-computed expectations.
// Timing-error checks are active when DRAM_TIMING_CHECK_EN is defined.

`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 8
`endif
`ifndef RAM_DATA_BITS
`define RAM_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_dram_core;

    localparam int CL = 5;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       CSn, RASn, CASn;
    logic [`AXI_STRB_BITS-1:0]  WEn;
    logic [`RAM_ADDR_BITS-1:0]  addrDRAM;
    logic [`RAM_DATA_BITS-1:0]  writeD;
    logic [`RAM_DATA_BITS-1:0]  readQ;
    logic [1:0]                 dramValid;
`ifdef DRAM_TIMING_CHECK_EN
    logic                       timingErr;
`endif

    int vectors     = 0;
    int miscompares = 0;

    dram_core #(.ADDR_W(16), .CL(CL), .TRCD(4), .TRP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .CSn       (CSn),
        .RASn      (RASn),
        .CASn      (CASn),
        .WEn       (WEn),
        .addrDRAM  (addrDRAM),
        .writeD    (writeD),
        .readQ     (readQ),
        .dramValid (dramValid)
`ifdef DRAM_TIMING_CHECK_EN
        ,
        .timingErr (timingErr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic csn, input logic rasn, input logic casn,
                         input logic [3:0] wen, input logic [7:0] a, input logic [31:0] d);
        CSn = csn; RASn = rasn; CASn = casn; WEn = wen; addrDRAM = a; writeD = d;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();                     drive(1'b1, 1'b1, 1'b1, 4'hF, 8'h00, 32'h0); endtask
    task automatic act(input logic [7:0] r);  drive(1'b0, 1'b0, 1'b1, 4'hF, r, 32'h0);    endtask
    task automatic pre();                     drive(1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 32'h0); endtask
    task automatic rd(input logic [7:0] c);   drive(1'b0, 1'b1, 1'b0, 4'hF, c, 32'h0);    endtask
    task automatic wr(input logic [7:0] c, input logic [31:0] d, input logic [3:0] wen);
        drive(1'b0, 1'b1, 1'b0, wen, c, d);
    endtask

    // Issue RD and verify dramValid stays low for CL-1 edges, then pulses with data.
    task automatic rd_check(input string tag, input logic [7:0] c, input logic [31:0] exp);
        rd(c);
        for (int k = 1; k <= CL; k++) begin
            nop();
            if (k < CL) begin
                chk({tag, "_early_valid"}, 32'(dramValid), 32'h0);
            end else begin
                chk({tag, "_valid"}, 32'(dramValid), 32'h3);
                chk({tag, "_data"}, readQ, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; addrDRAM = '0; writeD = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(dramValid), 32'h0);
        chk("reset_readq", readQ, 32'h0);
`ifdef DRAM_TIMING_CHECK_EN
        chk("reset_terr", 32'(timingErr), 32'h0);
`endif
        rst = 1'b1;
        nop();

        // Basic write then read of the same word on the next cycle.
        act(8'h03);
        repeat (3) nop();
        wr(8'h10, 32'hDEADBEEF, 4'h0);
        rd_check("basic", 8'h10, 32'hDEADBEEF);
        nop();
        chk("hold_valid", 32'(dramValid), 32'h0);
        chk("hold_readq", readQ, 32'hDEADBEEF);

        // Partial byte write.
        wr(8'h20, 32'hFFFFFFFF, 4'h0);
        wr(8'h20, 32'h00000000, 4'b1100);
        rd_check("bytewr", 8'h20, 32'hFFFF0000);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) wr(8'(i), 32'h11110000 + 32'(i), 4'h0);
        for (int i = 0; i < 4; i++) rd(8'(i));
        for (int k = 4; k <= 9; k++) begin
            nop();
            if (k >= 5 && k <= 8) begin
                chk("b2b_valid", 32'(dramValid), 32'h3);
                chk("b2b_data", readQ, 32'h11110000 + 32'(k - 5));
            end else begin
                chk("b2b_gap", 32'(dramValid), 32'h0);
            end
        end

        // Read followed by precharge still completes; read while idle is dropped.
        rd(8'h10);
        pre();
        for (int k = 2; k <= CL; k++) begin
            nop();
            if (k < CL) chk("rdpre_early", 32'(dramValid), 32'h0);
        end
        chk("rdpre_valid", 32'(dramValid), 32'h3);
        chk("rdpre_data", readQ, 32'hDEADBEEF);
        rd(8'h03);
`ifdef DRAM_TIMING_CHECK_EN
        chk("idle_rd_terr", 32'(timingErr), 32'h1);
`endif
        for (int k = 1; k <= CL + 1; k++) begin
            nop();
            chk("idle_rd_valid", 32'(dramValid), 32'h0);
        end
        chk("idle_rd_hold", readQ, 32'hDEADBEEF);

        // tRCD violation: RD two cycles after ACT is flagged yet serviced.
        act(8'h03);
`ifdef DRAM_TIMING_CHECK_EN
        chk("act_terr", 32'(timingErr), 32'h0);
`endif
        nop();
        rd(8'h03);
`ifdef DRAM_TIMING_CHECK_EN
        chk("trcd_terr", 32'(timingErr), 32'h1);
`endif
        for (int k = 1; k <= CL; k++) begin
            nop();
`ifdef DRAM_TIMING_CHECK_EN
            if (k == 1) chk("trcd_terr_pulse", 32'(timingErr), 32'h0);
`endif
            if (k < CL) chk("trcd_early", 32'(dramValid), 32'h0);
        end
        chk("trcd_valid", 32'(dramValid), 32'h3);
        chk("trcd_data", readQ, 32'h11110003);

        // Ignored commands leave row and contents untouched.
        act(8'h05);
`ifdef DRAM_TIMING_CHECK_EN
        chk("act_open_terr", 32'(timingErr), 32'h1);
`endif
        drive(1'b1, 1'b1, 1'b0, 4'h0, 8'h10, 32'h12345678);
`ifdef DRAM_TIMING_CHECK_EN
        chk("csn_high_terr", 32'(timingErr), 32'h0);
`endif
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h10, 32'h0);
`ifdef DRAM_TIMING_CHECK_EN
        chk("rascas_terr", 32'(timingErr), 32'h1);
`endif
        drive(1'b0, 1'b0, 1'b1, 4'b0101, 8'h00, 32'h0);
`ifdef DRAM_TIMING_CHECK_EN
        chk("mixed_we_terr", 32'(timingErr), 32'h1);
`endif
        rd_check("ignored", 8'h10, 32'hDEADBEEF);

        // Reset two cycles after a RD drops the read, keeps the array.
        rd(8'h20);
        nop();
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(dramValid), 32'h0);
        chk("rst_mid_readq", readQ, 32'h0);
        nop();
        nop();
        rst = 1'b1;
        for (int k = 0; k < CL; k++) begin
            nop();
            chk("rst_drop_valid", 32'(dramValid), 32'h0);
        end
        act(8'h03);
        repeat (3) nop();
        rd_check("post_rst_a", 8'h20, 32'hFFFF0000);
        rd_check("post_rst_b", 8'h10, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
